int_div_iter: RTL



---
 rtl/int_div_iter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/int_div_iter.sv
// Iterative 32-bit signed/unsigned divider, one restoring step per cycle, quotient and remainder out.
// Latency: 32 CALC cycles + DONE; INT_DIV_EARLY_EXIT_EN skips leading zeros of |a| (32 - lz(|a|) CALC cycles).
// Backpressure: single op in flight; DONE holds the result until ostream_rdy, istream_rdy low until then.
module int_div_iter (
  input  logic        clk,
  input  logic        reset,
  input  logic        istream_val,
  output logic        istream_rdy,
  input  logic [64:0] istream_msg,
  output logic        ostream_val,
  input  logic        ostream_rdy,
  output logic [63:0] ostream_msg
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [32:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] div_q;
  logic        negq_q;
  logic        negr_q;
  logic        rdy_q;
  logic        val_q;

  logic        sgn;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic        b_zero;
  logic [4:0]  ld_cnt_d;
  logic [31:0] ld_quo_d;

  logic [33:0] diff;
  logic        qbit;
  logic [32:0] rem_d;
  logic [31:0] quo_d;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

`ifdef INT_DIV_EARLY_EXIT_EN
  logic [5:0] lz;
  logic [4:0] lz5;

  function automatic logic [5:0] clz32(input logic [31:0] v);
    logic [5:0] n;
    n = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) n = 6'(31 - i);
    end
    return n;
  endfunction
`endif

  always_comb begin
    sgn    = istream_msg[64];
    op_a   = istream_msg[63:32];
    op_b   = istream_msg[31:0];
    abs_a  = (sgn && op_a[31]) ? (32'd0 - op_a) : op_a;
    abs_b  = (sgn && op_b[31]) ? (32'd0 - op_b) : op_b;
    b_zero = (op_b == 32'd0);
`ifdef INT_DIV_EARLY_EXIT_EN
    lz       = clz32(abs_a);
    lz5      = (lz > 6'd31) ? 5'd31 : lz[4:0];
    ld_cnt_d = 5'd31 - lz5;
    // Skipped steps would have shifted in 1s when dividing by zero; pre-fill them.
    ld_quo_d = (abs_a << lz5) | (b_zero ? ~({32{1'b1}} << lz5) : 32'd0);
`else
    ld_cnt_d = 5'd31;
    ld_quo_d = abs_a;
`endif
  end

  // rem_q[32] is always zero, so the 34-bit difference sign matches the 33-bit one.
  always_comb begin
    diff  = {rem_q, quo_q[31]} - {2'b00, div_q};
    qbit  = ~diff[33];
    rem_d = qbit ? diff[32:0] : {rem_q[31:0], quo_q[31]};
    quo_d = {quo_q[30:0], qbit};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      rem_q   <= 33'd0;
      quo_q   <= 32'd0;
      div_q   <= 32'd0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      rdy_q   <= 1'b0;
      val_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rdy_q <= 1'b1;
          if (istream_val && rdy_q) begin
            rem_q   <= 33'd0;
            quo_q   <= ld_quo_d;
            div_q   <= abs_b;
            cnt_q   <= ld_cnt_d;
            negq_q  <= sgn && (op_a[31] ^ op_b[31]) && !b_zero;
            negr_q  <= sgn && op_a[31];
            rdy_q   <= 1'b0;
            state_q <= CALC;
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          if (cnt_q == 5'd0) begin
            val_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        DONE: begin
          if (ostream_rdy) begin
            val_q   <= 1'b0;
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          val_q   <= 1'b0;
          rdy_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    quo_fix = negq_q ? (32'd0 - quo_q) : quo_q;
    rem_fix = negr_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];
  end

  assign istream_rdy = rdy_q;
  assign ostream_val = val_q;
  assign ostream_msg = val_q ? {rem_fix, quo_fix} : 64'd0;

endmodule
